uart_rx_pkt_ctrl: RTL and testbench

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_pkt_ctrl_if.sv | 29 ++
 rtl/uart_byte_timer.sv | 37 +++
 rtl/uart_rx_pkt_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART packet-layer types and constants.
// FSM states, abort causes, framing limits and default bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_CSUM    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_FRAME   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int MAX_LEN = 8;
  localparam int DEF_CLKS_PER_BIT = 217;

  function automatic logic len_ok(
    input logic [7:0] b
  );
    return (b != 8'd0) && (b <= 8'(MAX_LEN));
  endfunction

endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// Bus between the UART byte source / readback user and the packet
// controller. master: rx_* and rd_addr out; slave: status and rd_data out.
interface uart_rx_pkt_ctrl_if;

  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_frame_err;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] pkt_len;
  logic [7:0] led_data;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;
  logic [7:0] err_count;

  modport master (
    output rx_byte, rx_byte_valid, rx_frame_err, rd_addr,
    input  rd_data, pkt_len, led_data, pkt_ok, pkt_err,
    input  err_code, err_count
  );

  modport slave (
    input  rx_byte, rx_byte_valid, rx_frame_err, rd_addr,
    output rd_data, pkt_len, led_data, pkt_ok, pkt_err,
    output err_code, err_count
  );

endinterface

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter. Ports: clk, rst, clear_i (reload),
// run_i (count enable), expired_o (high on the last count of a window).
module uart_byte_timer #(
  parameter int TIMEOUT_CLKS = 8680
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A reload on the same cycle hides expiry: the fresh byte wins.
  assign expired_o = run_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || !run_i || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind a UART receiver: SYNC, LEN, payload, XOR csum.
// Ports: clk, rst, bus (slave): rx bytes in, committed payload/status out.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = CLKS_PER_BIT * 40
) (
  input  logic                clk,
  input  logic                rst,
  uart_rx_pkt_ctrl_if.slave   bus
);

  state_e     state_q;
  logic [3:0] len_q;
  logic [2:0] idx_q;
  logic [7:0] csum_q;
  logic [7:0] shadow_q [MAX_LEN];
  logic [7:0] comm_q   [MAX_LEN];
  logic [3:0] pkt_len_q;
  logic [7:0] led_q;
  logic       ok_q;
  logic       err_q;
  err_e       code_q;
  logic [7:0] cnt_q;

  logic       byte_v;
  logic [7:0] rxb;
  logic       in_pkt;
  logic       expired;
  logic       abort;
  logic       commit;
  err_e       cause;
  logic       last_byte;

  assign byte_v = bus.rx_byte_valid;
  assign rxb    = bus.rx_byte;
  assign in_pkt = (state_q != ST_IDLE);

  assign last_byte = (({1'b0, idx_q} + 4'd1) == len_q);

  uart_byte_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (byte_v),
    .run_i    (in_pkt),
    .expired_o(expired)
  );

  // Priority: frame error, then byte, then timeout.
  always_comb begin
    abort  = 1'b0;
    commit = 1'b0;
    cause  = ERR_CSUM;
    if (in_pkt && bus.rx_frame_err) begin
      abort = 1'b1;
      cause = ERR_FRAME;
    end else if (byte_v) begin
      unique case (state_q)
        ST_LEN: begin
          if (!len_ok(rxb)) begin
            abort = 1'b1;
            cause = ERR_LEN;
          end
        end
        ST_CHECK: begin
          if (rxb == csum_q) begin
            commit = 1'b1;
          end else begin
            abort = 1'b1;
            cause = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end else if (in_pkt && expired) begin
      abort = 1'b1;
      cause = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= 4'd0;
      idx_q     <= 3'd0;
      csum_q    <= 8'h00;
      pkt_len_q <= 4'd0;
      led_q     <= 8'h00;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_CSUM;
      cnt_q     <= 8'd0;
      for (int i = 0; i < MAX_LEN; i++) begin
        shadow_q[i] <= 8'h00;
        comm_q[i]   <= 8'h00;
      end
    end else begin
      ok_q  <= commit;
      err_q <= abort;
      if (abort) begin
        state_q <= ST_IDLE;
        code_q  <= cause;
        if (cnt_q != 8'hFF) begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else if (byte_v) begin
        unique case (state_q)
          ST_IDLE: begin
            if (rxb == SYNC_BYTE) begin
              state_q <= ST_LEN;
            end
          end
          ST_LEN: begin
            len_q   <= rxb[3:0];
            csum_q  <= rxb;
            idx_q   <= 3'd0;
            state_q <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            shadow_q[idx_q] <= rxb;
            csum_q          <= csum_q ^ rxb;
            idx_q           <= idx_q + 3'd1;
            if (last_byte) begin
              state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            // Bytes past len keep their old committed value.
            for (int i = 0; i < MAX_LEN; i++) begin
              if (i < int'(len_q)) begin
                comm_q[i] <= shadow_q[i];
              end
            end
            pkt_len_q <= len_q;
            led_q     <= shadow_q[0];
            state_q   <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rd_data   = comm_q[bus.rd_addr];
  assign bus.pkt_len   = pkt_len_q;
  assign bus.led_data  = led_q;
  assign bus.pkt_ok    = ok_q;
  assign bus.pkt_err   = err_q;
  assign bus.err_code  = code_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl.
// Vector table, directed corner sequences, random packets vs model.
module tb_uart_rx_pkt_ctrl;
  import uart_pkg::*;

  localparam int TMO = 8680;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_pkt_ctrl_if bus();

  uart_rx_pkt_ctrl #(
    .CLKS_PER_BIT(217),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Reference model: packet-level view of the byte stream.
  logic [7:0] mq[$];
  int         gap;
  logic       m_ok, m_err;
  logic [1:0] m_code;
  int         m_cnt;
  int         m_len;
  logic [7:0] m_led;
  logic [7:0] m_mem[8];

  task automatic m_reset();
    mq.delete();
    gap = 0; m_ok = 0; m_err = 0; m_code = 0;
    m_cnt = 0; m_len = 0; m_led = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 0;
  endtask

  task automatic m_abort(int c);
    m_err = 1;
    m_code = 2'(c);
    if (m_cnt < 255) m_cnt++;
    mq.delete();
    gap = 0;
  endtask

  task automatic m_byte(logic [7:0] b);
    logic [7:0] x;
    gap = 0;
    if (mq.size() == 0) begin
      if (b == 8'hA5) mq.push_back(b);
    end else if (mq.size() == 1) begin
      if (b >= 1 && b <= 8) mq.push_back(b);
      else m_abort(1);
    end else begin
      mq.push_back(b);
      if (mq.size() == int'(mq[1]) + 3) begin
        x = 0;
        for (int i = 1; i < mq.size() - 1; i++) x ^= mq[i];
        if (x == b) begin
          m_ok = 1;
          m_len = int'(mq[1]);
          m_led = mq[2];
          for (int i = 0; i < m_len; i++) m_mem[i] = mq[2+i];
        end else begin
          m_abort(0);
        end
        mq.delete();
      end
    end
  endtask

  task automatic m_step(logic v, logic [7:0] b, logic fe);
    m_ok = 0;
    m_err = 0;
    if (mq.size() != 0 && fe) m_abort(2);
    else if (v) m_byte(b);
    else if (mq.size() != 0) begin
      gap++;
      if (gap == TMO) m_abort(3);
    end
  endtask

  // One clock: drive at negedge, sample at the following negedge.
  task automatic cyc(logic v, logic [7:0] b, logic fe, logic [2:0] ra);
    bus.rx_byte_valid = v;
    bus.rx_byte = b;
    bus.rx_frame_err = fe;
    bus.rd_addr = ra;
    @(negedge clk);
    bus.rx_byte_valid = 0;
    bus.rx_frame_err = 0;
    m_step(v, b, fe);
    chk("pkt_ok", bus.pkt_ok, m_ok);
    chk("pkt_err", bus.pkt_err, m_err);
    chk("ok_err_excl", bus.pkt_ok & bus.pkt_err, 0);
    chk("err_code", bus.err_code, m_code);
    chk("err_count", bus.err_count, m_cnt);
    chk("pkt_len", bus.pkt_len, m_len);
    chk("led_data", bus.led_data, m_led);
    chk("rd_data", bus.rd_data, m_mem[ra]);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 3'($urandom_range(0, 7)));
  endtask

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic       fe;
    logic [2:0] ra;
    logic       ok;
    logic       err;
    logic [1:0] code;
    logic [7:0] cnt;
    logic [3:0] len;
    logic [7:0] led;
    logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(
    logic v, logic [7:0] b, logic fe, logic [2:0] ra,
    logic ok, logic err, logic [1:0] code, logic [7:0] cnt,
    logic [3:0] len, logic [7:0] led, logic [7:0] rd);
    vec_t t;
    t.v = v; t.b = b; t.fe = fe; t.ra = ra;
    t.ok = ok; t.err = err; t.code = code; t.cnt = cnt;
    t.len = len; t.led = led; t.rd = rd;
    return t;
  endfunction

  vec_t tbl[20];

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    logic [7:0] pk[$];
    logic [7:0] x;
    int n, kind, fpos;

    tbl[0]  = mk(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[1]  = mk(1, 8'h02, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[2]  = mk(1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[3]  = mk(1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[4]  = mk(1, 8'h31, 0, 0, 1, 0, 0, 0, 2, 8'h11, 8'h11);
    tbl[5]  = mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 2, 8'h11, 8'h22);
    tbl[6]  = mk(1, 8'hA5, 0, 0, 0, 0, 0, 0, 2, 8'h11, 8'h11);
    tbl[7]  = mk(1, 8'h02, 0, 0, 0, 0, 0, 0, 2, 8'h11, 8'h11);
    tbl[8]  = mk(1, 8'h11, 0, 0, 0, 0, 0, 0, 2, 8'h11, 8'h11);
    tbl[9]  = mk(1, 8'h22, 0, 0, 0, 0, 0, 0, 2, 8'h11, 8'h11);
    tbl[10] = mk(1, 8'h30, 0, 0, 0, 1, 0, 1, 2, 8'h11, 8'h11);
    tbl[11] = mk(1, 8'h00, 0, 0, 0, 0, 0, 1, 2, 8'h11, 8'h11);
    tbl[12] = mk(1, 8'hA5, 0, 0, 0, 0, 0, 1, 2, 8'h11, 8'h11);
    tbl[13] = mk(1, 8'h09, 0, 0, 0, 1, 1, 2, 2, 8'h11, 8'h11);
    tbl[14] = mk(1, 8'hA5, 0, 0, 0, 0, 1, 2, 2, 8'h11, 8'h11);
    tbl[15] = mk(1, 8'h01, 0, 0, 0, 0, 1, 2, 2, 8'h11, 8'h11);
    tbl[16] = mk(1, 8'h7E, 0, 0, 0, 0, 1, 2, 2, 8'h11, 8'h11);
    tbl[17] = mk(1, 8'h7F, 0, 0, 1, 0, 1, 2, 1, 8'h7E, 8'h7E);
    tbl[18] = mk(0, 8'h00, 0, 1, 0, 0, 1, 2, 1, 8'h7E, 8'h22);
    tbl[19] = mk(1, 8'h05, 1, 0, 0, 0, 1, 2, 1, 8'h7E, 8'h7E);

    bus.rx_byte = 0;
    bus.rx_byte_valid = 0;
    bus.rx_frame_err = 0;
    bus.rd_addr = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_pkt_ok", bus.pkt_ok, 0);
    chk("rst_pkt_err", bus.pkt_err, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_pkt_len", bus.pkt_len, 0);
    chk("rst_led", bus.led_data, 0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].v, tbl[i].b, tbl[i].fe, tbl[i].ra);
      chk($sformatf("t%0d_ok", i), bus.pkt_ok, tbl[i].ok);
      chk($sformatf("t%0d_err", i), bus.pkt_err, tbl[i].err);
      chk($sformatf("t%0d_code", i), bus.err_code, tbl[i].code);
      chk($sformatf("t%0d_cnt", i), bus.err_count, tbl[i].cnt);
      chk($sformatf("t%0d_len", i), bus.pkt_len, tbl[i].len);
      chk($sformatf("t%0d_led", i), bus.led_data, tbl[i].led);
      chk($sformatf("t%0d_rd", i), bus.rd_data, tbl[i].rd);
    end

    // Timeout: full idle window after the last byte.
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h01, 0, 0);
    idle(TMO - 1);
    cyc(0, 8'h00, 0, 0);
    chk("tmo_err", bus.pkt_err, 1);
    chk("tmo_code", bus.err_code, 3);
    idle(2);

    // Byte lands on the expiry cycle: reload, no error.
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h01, 0, 0);
    idle(TMO - 1);
    cyc(1, 8'h02, 0, 0);
    chk("tmo_race_err", bus.pkt_err, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h03, 0, 2);
    chk("tmo_race_ok", bus.pkt_ok, 1);
    chk("tmo_race_rd", bus.rd_data, 8'h03);

    // Frame error with a same-cycle payload byte.
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'h02, 0, 0);
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 1, 0);
    chk("frame_err", bus.pkt_err, 1);
    chk("frame_code", bus.err_code, 2);
    idle(1);

    // Saturate the abort counter.
    for (int i = 0; i < 256; i++) begin
      cyc(1, 8'hA5, 0, 0);
      cyc(1, 8'h00, 0, 0);
    end
    chk("sat_count", bus.err_count, 255);
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'h0C, 0, 0);
    chk("sat_hold", bus.err_count, 255);
    idle(1);

    // Random traffic against the model.
    for (int it = 0; it < 300; it++) begin
      kind = $urandom_range(0, 9);
      n = $urandom_range(1, 8);
      pk.delete();
      pk.push_back(8'hA5);
      pk.push_back(8'(n));
      x = 8'(n);
      for (int j = 0; j < n; j++) begin
        pk.push_back(8'($urandom));
        x ^= pk[j+2];
      end
      pk.push_back(x);
      if (kind == 6) pk[n+2] = x ^ (8'h01 << $urandom_range(0, 7));
      if (kind == 7) begin
        pk.delete();
        pk.push_back(8'hA5);
        pk.push_back(($urandom_range(0, 1) == 0) ? 8'h00
                     : 8'($urandom_range(9, 255)));
      end
      if (kind == 8) begin
        pk.delete();
        pk.push_back(8'($urandom));
      end
      fpos = (kind == 9) ? $urandom_range(1, pk.size() - 1) : -1;
      for (int j = 0; j < pk.size(); j++) begin
        idle($urandom_range(0, 2));
        if (j == fpos && $urandom_range(0, 1) == 0)
          cyc(0, 8'h00, 1, 3'($urandom_range(0, 7)));
        else
          cyc(1, pk[j], (j == fpos), 3'($urandom_range(0, 7)));
      end
    end
    idle(2);

    // Reset mid-payload: outputs clear, no abort pulse.
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'h03, 0, 0);
    cyc(1, 8'h11, 0, 0);
    rst = 1;
    #1;
    m_reset();
    chk("mid_rst_ok", bus.pkt_ok, 0);
    chk("mid_rst_err", bus.pkt_err, 0);
    chk("mid_rst_cnt", bus.err_count, 0);
    chk("mid_rst_code", bus.err_code, 0);
    chk("mid_rst_len", bus.pkt_len, 0);
    chk("mid_rst_led", bus.led_data, 0);
    chk("mid_rst_rd", bus.rd_data, 0);
    @(negedge clk);
    rst = 0;
    idle(3);
    cyc(1, 8'h22, 0, 0);
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'h01, 0, 0);
    cyc(1, 8'h55, 0, 0);
    cyc(1, 8'h54, 0, 0);
    chk("post_rst_ok", bus.pkt_ok, 1);
    chk("post_rst_led", bus.led_data, 8'h55);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
